pong_engine: RTL and testbench

- Frame-rate game-logic core for the two-player VGA Pong design: owns ball position/velocity, both paddle positions, collision detection, scoring and serve/game-over sequencing.
- Sits between the CPU custom-instruction interface (paddle writes, start) and the pixel renderers; its outputs feed the bar/ball drawing blocks and the score readback word.
- Generalises the fixed two-bar/free-running-ball arrangement with parametrised geometry, speed, real collisions, scores and a game FSM.

---
 rtl/pong_engine.sv | 192 +++++++++++++++++++
 tb/tb_pong_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// Pong game core: ball/paddle state, collisions, scoring and the IDLE/SERVE/PLAY/OVER sequencer.
// All outputs registered (one cycle after frame_tick/wr_en/start); no backpressure, every strobe is accepted.
module pong_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PAD_H        = 80,
    parameter int PAD_W        = 10,
    parameter int PAD1_X       = 10,
    parameter int PAD2_X       = 620,
    parameter int BALL_SZ      = 8,
    parameter int BALL_SPD     = 2,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        frame_tick,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        start,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [9:0]  pad1_y,
    output logic [9:0]  pad2_y,
    output logic [7:0]  score1,
    output logic [7:0]  score2,
    output logic [1:0]  state,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    localparam logic [9:0] CX      = 10'((H_RES - BALL_SZ) / 2);
    localparam logic [9:0] CY      = 10'((V_RES - BALL_SZ) / 2);
    localparam logic [9:0] PMAX    = 10'(V_RES - PAD_H);
    localparam logic [9:0] PMID    = 10'((V_RES - PAD_H) / 2);
    localparam logic [9:0] YMAX    = 10'(V_RES - BALL_SZ);
    localparam logic [9:0] HIT_L_X = 10'(PAD1_X + PAD_W);
    localparam logic [9:0] HIT_R_X = 10'(PAD2_X - BALL_SZ);
    localparam logic [9:0] SF      = 10'(SERVE_FRAMES);
    localparam logic [7:0] WIN     = 8'(WIN_SCORE);

    localparam logic signed [11:0] S_SPD  = 12'(BALL_SPD);
    localparam logic signed [11:0] S_B    = 12'(BALL_SZ);
    localparam logic signed [11:0] S_PH   = 12'(PAD_H);
    localparam logic signed [11:0] S_P1L  = 12'(PAD1_X);
    localparam logic signed [11:0] S_P1R  = 12'(PAD1_X + PAD_W);
    localparam logic signed [11:0] S_P2L  = 12'(PAD2_X);
    localparam logic signed [11:0] S_P2R  = 12'(PAD2_X + PAD_W);
    localparam logic signed [11:0] S_H    = 12'(H_RES);
    localparam logic signed [11:0] S_YMAX = 12'(V_RES - BALL_SZ);

    state_t      st_q, st_d;
    logic [9:0]  bx_q, bx_d, by_q, by_d, p1_q, p1_d, p2_q, p2_d, cnt_q, cnt_d;
    logic [7:0]  s1_q, s1_d, s2_q, s2_d;
    logic        dx_q, dx_d, dy_q, dy_d;

    logic signed [11:0] bx_s, by_s, p1_s, p2_s, nx, ny;
    logic [9:0]  wr_y, vy;
    logic        vdy, ov1, ov2, hit1, hit2, miss1, miss2;
    logic        unused_wr;

    assign unused_wr = ^wr_data[31:11];

    assign bx_s = signed'({2'b00, bx_q});
    assign by_s = signed'({2'b00, by_q});
    assign p1_s = signed'({2'b00, p1_q});
    assign p2_s = signed'({2'b00, p2_q});
    assign nx   = dx_q ? bx_s + S_SPD : bx_s - S_SPD;
    assign ny   = dy_q ? by_s + S_SPD : by_s - S_SPD;
    assign wr_y = (wr_data[9:0] > PMAX) ? PMAX : wr_data[9:0];

    // Collisions look at the registered paddles, so a same-cycle write only affects later frames.
    assign ov1   = (by_s + S_B > p1_s) && (by_s < p1_s + S_PH);
    assign ov2   = (by_s + S_B > p2_s) && (by_s < p2_s + S_PH);
    assign hit1  = !dx_q && (nx <= S_P1R) && (nx + S_B > S_P1L) && ov1;
    assign hit2  = dx_q && (nx + S_B >= S_P2L) && (nx < S_P2R) && ov2;
    assign miss1 = !hit1 && !hit2 && (nx <= 12'sd0);
    assign miss2 = !hit1 && !hit2 && (nx + S_B >= S_H);

    always_comb begin
        vy  = ny[9:0];
        vdy = dy_q;
        if (ny <= 12'sd0) begin
            vy  = '0;
            vdy = 1'b1;
        end else if (ny >= S_YMAX) begin
            vy  = YMAX;
            vdy = 1'b0;
        end
    end

    always_comb begin
        st_d  = st_q;
        bx_d  = bx_q;
        by_d  = by_q;
        p1_d  = p1_q;
        p2_d  = p2_q;
        cnt_d = cnt_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        if (wr_en) begin
            if (wr_data[10]) p2_d = wr_y;
            else             p1_d = wr_y;
        end
        case (st_q)
            IDLE: if (start) begin
                st_d  = SERVE;
                cnt_d = '0;
            end
            SERVE: if (frame_tick) begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_d == SF) st_d = PLAY;
            end
            PLAY: if (frame_tick) begin
                if (miss1 || miss2) begin
                    // Point scored: dy is deliberately left as it was before this frame.
                    bx_d  = CX;
                    by_d  = CY;
                    cnt_d = '0;
                    if (miss1) begin
                        dx_d = 1'b0;
                        s2_d = s2_q + 8'd1;
                    end else begin
                        dx_d = 1'b1;
                        s1_d = s1_q + 8'd1;
                    end
                    st_d = (s1_d == WIN || s2_d == WIN) ? OVER : SERVE;
                end else begin
                    by_d = vy;
                    dy_d = vdy;
                    if (hit1) begin
                        bx_d = HIT_L_X;
                        dx_d = 1'b1;
                    end else if (hit2) begin
                        bx_d = HIT_R_X;
                        dx_d = 1'b0;
                    end else begin
                        bx_d = nx[9:0];
                    end
                end
            end
            OVER: if (start) begin
                s1_d  = '0;
                s2_d  = '0;
                bx_d  = CX;
                by_d  = CY;
                dx_d  = 1'b1;
                dy_d  = 1'b1;
                cnt_d = '0;
                st_d  = SERVE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_BTN) begin
        if (RST_BTN) begin
            st_q  <= IDLE;
            bx_q  <= CX;
            by_q  <= CY;
            p1_q  <= PMID;
            p2_q  <= PMID;
            cnt_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            dx_q  <= 1'b1;
            dy_q  <= 1'b1;
        end else begin
            st_q  <= st_d;
            bx_q  <= bx_d;
            by_q  <= by_d;
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            cnt_q <= cnt_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
        end
    end

    assign ball_x = bx_q;
    assign ball_y = by_q;
    assign pad1_y = p1_q;
    assign pad2_y = p2_q;
    assign score1 = s1_q;
    assign score2 = s2_q;
    assign state  = st_q;
    assign result = {13'b0, (st_q == OVER), st_q, s2_q, s1_q};
endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: paddle-write vector table, directed serve/wall/hit/miss/win sequences,
// then randomized play, all against a frame-level reference model of the game rules.
module tb_pong_engine;
    localparam int H = 640, V = 480, PH = 80, PW = 10, P1X = 10, P2X = 620;
    localparam int B = 8, SPD = 2, WIN = 2, SF = 3;
    localparam int CX = (H - B) / 2, CY = (V - B) / 2, PMID = (V - PH) / 2;

    logic        CLK = 1'b0;
    logic        RST_BTN, frame_tick, wr_en, start;
    logic [31:0] wr_data;
    logic [9:0]  ball_x, ball_y, pad1_y, pad2_y;
    logic [7:0]  score1, score2;
    logic [1:0]  state;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    int m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_st, m_dx, m_dy, m_cnt;

    typedef struct {
        logic [31:0] wd;
        int          p1;
        int          p2;
    } vec_t;
    vec_t vecs [0:8];

    pong_engine #(
        .H_RES(H), .V_RES(V), .PAD_H(PH), .PAD_W(PW), .PAD1_X(P1X), .PAD2_X(P2X),
        .BALL_SZ(B), .BALL_SPD(SPD), .WIN_SCORE(WIN), .SERVE_FRAMES(SF)
    ) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .frame_tick(frame_tick), .wr_en(wr_en),
        .wr_data(wr_data), .start(start), .ball_x(ball_x), .ball_y(ball_y),
        .pad1_y(pad1_y), .pad2_y(pad2_y), .score1(score1), .score2(score2),
        .state(state), .result(result)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string name);
        logic [71:0] act, exp;
        act = {ball_x, ball_y, pad1_y, pad2_y, result};
        exp = {10'(m_bx), 10'(m_by), 10'(m_p1), 10'(m_p2), 13'd0, (m_st == 3), 2'(m_st),
               8'(m_s2), 8'(m_s1)};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bx = CX; m_by = CY; m_p1 = PMID; m_p2 = PMID;
        m_s1 = 0; m_s2 = 0; m_st = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
    endtask

    // One clock of the game rules, positions as plain integers and directions as +1/-1.
    task automatic model_step(input logic fr, input logic we, input logic [31:0] wd, input logic st);
        int np1, np2, v, nx, ny, vy, vdy;
        bit hl, hr;
        np1 = m_p1;
        np2 = m_p2;
        if (we) begin
            v = int'(wd[9:0]);
            if (v > V - PH) v = V - PH;
            if (wd[10]) np2 = v;
            else        np1 = v;
        end
        case (m_st)
            0: if (st) begin m_st = 1; m_cnt = 0; end
            1: if (fr) begin
                m_cnt++;
                if (m_cnt == SF) m_st = 2;
            end
            2: if (fr) begin
                nx = m_bx + m_dx * SPD;
                ny = m_by + m_dy * SPD;
                vy = ny;
                vdy = m_dy;
                if (ny <= 0) begin vy = 0; vdy = 1; end
                else if (ny >= V - B) begin vy = V - B; vdy = -1; end
                hl = (m_dx < 0) && (nx <= P1X + PW) && (nx + B > P1X) &&
                     (m_by + B > m_p1) && (m_by < m_p1 + PH);
                hr = (m_dx > 0) && (nx + B >= P2X) && (nx < P2X + PW) &&
                     (m_by + B > m_p2) && (m_by < m_p2 + PH);
                if (hl) begin
                    m_bx = P1X + PW; m_dx = 1; m_by = vy; m_dy = vdy;
                end else if (hr) begin
                    m_bx = P2X - B; m_dx = -1; m_by = vy; m_dy = vdy;
                end else if (nx <= 0 || nx + B >= H) begin
                    if (nx <= 0) begin m_s2++; m_dx = -1; end
                    else         begin m_s1++; m_dx = 1;  end
                    m_bx = CX; m_by = CY; m_cnt = 0;
                    m_st = (m_s1 == WIN || m_s2 == WIN) ? 3 : 1;
                end else begin
                    m_bx = nx; m_by = vy; m_dy = vdy;
                end
            end
            3: if (st) begin
                m_s1 = 0; m_s2 = 0; m_bx = CX; m_by = CY;
                m_dx = 1; m_dy = 1; m_cnt = 0; m_st = 1;
            end
            default: ;
        endcase
        m_p1 = np1;
        m_p2 = np2;
    endtask

    task automatic cycle(input logic fr, input logic we, input logic [31:0] wd, input logic st);
        frame_tick = fr; wr_en = we; wr_data = wd; start = st;
        @(posedge CLK);
        model_step(fr, we, wd, st);
        #1;
        frame_tick = 1'b0; wr_en = 1'b0; start = 1'b0;
        chk_all("cycle");
    endtask

    initial begin
        RST_BTN = 1'b1; frame_tick = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0;
        model_reset();
        vecs[0] = '{32'h0000_03FF, 400, 200};
        vecs[1] = '{32'h0000_0432, 400, 50};
        vecs[2] = '{32'h0000_0000, 0, 50};
        vecs[3] = '{32'h0000_07FF, 0, 400};
        vecs[4] = '{32'h0000_0190, 400, 400};
        vecs[5] = '{32'h0000_058F, 400, 399};
        vecs[6] = '{32'hFFFF_F864, 100, 399};
        vecs[7] = '{32'h0000_00C8, 200, 399};
        vecs[8] = '{32'h0000_04C8, 200, 200};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ball_x", ball_x, 316);
        chk("rst_ball_y", ball_y, 236);
        chk("rst_pad1", pad1_y, 200);
        chk("rst_pad2", pad2_y, 200);
        chk("rst_state", state, 0);
        chk("rst_result", result, 0);
        RST_BTN = 1'b0;

        cycle(1, 0, 0, 0);
        chk("idle_tick_ball_x", ball_x, 316);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, vecs[i].wd, 0);
            chk("pad1_vec", pad1_y, vecs[i].p1);
            chk("pad2_vec", pad2_y, vecs[i].p2);
        end

        // Serve timing, then round A: ball runs down-right past pad2 for a right miss.
        cycle(0, 0, 0, 1);
        chk("serve_state", state, 1);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("serve_hold", state, 1);
        cycle(1, 0, 0, 0);
        chk("serve_to_play", state, 2);
        chk("serve_no_move", ball_x, 316);
        cycle(1, 0, 0, 0);
        chk("first_move_x", ball_x, 318);
        chk("first_move_y", ball_y, 238);
        cycle(0, 0, 0, 1);
        chk("start_in_play", state, 2);
        for (int n = 0; n < 400 && m_st == 2; n++) cycle(1, 0, 0, 0);
        chk("missA_score1", score1, 1);
        chk("missA_state", state, 1);
        chk("missA_recentre", ball_x, 316);

        // Round B: serve heads right again, ball climbs to the top wall, then misses right.
        for (int n = 0; n < 10 && m_st == 1; n++) cycle(1, 0, 0, 0);
        chk("serveB_play", state, 2);
        cycle(1, 0, 0, 0);
        chk("serveB_dir", ball_x, 318);
        for (int n = 0; n < 400 && m_by != 0; n++) cycle(1, 0, 0, 0);
        chk("wall_top", ball_y, 0);
        cycle(1, 0, 0, 0);
        chk("wall_bounce", ball_y, 2);
        for (int n = 0; n < 400 && m_st == 2; n++) cycle(1, 0, 0, 0);
        chk("win_state", state, 3);
        chk("win_score1", score1, 2);
        chk("win_result", result, 32'h0007_0002);

        cycle(0, 1, 32'h0000_03FF, 0);
        chk("over_pad_write", pad1_y, 400);
        cycle(1, 0, 0, 0);
        chk("over_frozen", ball_x, 316);
        cycle(0, 0, 0, 1);
        chk("restart_state", state, 1);
        chk("restart_result", result, 32'h0001_0000);

        // Round C: pad2 placed where the ball arrives; write lands on the hit frame.
        cycle(0, 1, 32'h0000_057C, 0);
        for (int n = 0; n < 400 && m_bx != 610; n++) cycle(1, 0, 0, 0);
        chk("pre_hit_x", ball_x, 610);
        cycle(1, 1, 32'h0000_0400, 0);
        chk("hit_x", ball_x, 612);
        chk("hit_pad2_written", pad2_y, 0);
        cycle(1, 0, 0, 0);
        chk("hit_reverse", ball_x, 610);

        for (int i = 0; i < 6000; i++) begin
            logic        fr, we, st, sel;
            logic [31:0] wd;
            int          t;
            fr  = ($urandom % 3) == 0;
            we  = ($urandom % 8) == 0;
            st  = ($urandom % 64) == 0;
            sel = $urandom % 2;
            if ($urandom % 2) begin
                t = m_by - 36 + int'($urandom_range(0, 60)) - 30;
                if (t < 0) t = 0;
                wd = {21'd0, sel, 10'(t)};
            end else begin
                wd = $urandom;
            end
            cycle(fr, we, wd, st);
        end

        for (int n = 0; n < 300 && m_st != 2; n++) cycle(1, 0, 0, (m_st == 0 || m_st == 3));
        chk("play_before_reset", state, 2);
        #2;
        RST_BTN = 1'b1;
        #1;
        chk("midrst_ball_x", ball_x, 316);
        chk("midrst_ball_y", ball_y, 236);
        chk("midrst_pad1", pad1_y, 200);
        chk("midrst_pad2", pad2_y, 200);
        chk("midrst_scores", {score2, score1}, 0);
        chk("midrst_state", state, 0);
        chk("midrst_result", result, 0);
        model_reset();
        @(posedge CLK);
        #1;
        RST_BTN = 1'b0;
        chk_all("after_reset");
        cycle(1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
